bcd_down_counter: RTL and testbench

- Multi-digit BCD decade down counter. It is the countdown counterpart of the team's 0–9 decade up counter.
- Loads a BCD preset and decrements one count per enabled clock.
- Flags the zero count and signals the 00..0 -> 99..9 wrap with a borrow pulse.
- Used as a countdown timer or as a cascadable decade divider stage in the sample designs.

---
 rtl/bcd_down_counter.sv | 120 ++++++++++++
 tb/tb_bcd_down_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD decade down counter with synchronous load,
// zero flag, wrap borrow pulse and reach-zero done pulse.
// Optional build macro BCD_DOWN_COUNTER_SATURATE_EN: when defined the count
// sticks at all-zero instead of wrapping to all-nines, and borrow never asserts.
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  // Count value of exactly one; a decrement from here produces done.
  localparam logic [W-1:0] COUNT_ONE = {{(W-4){1'b0}}, 4'd1};

  // Clamp a single digit into the BCD range so a bad preset cannot
  // push the counter out of decimal.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    logic [3:0] r;
    r = (d > 4'd9) ? 4'd9 : d;
    return r;
  endfunction

  // Apply the per-digit clamp across the whole preset word.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = clamp_digit(v[4*i +: 4]);
    end
    return r;
  endfunction

  // Ripple-borrow BCD decrement: digit 0 always steps; a higher digit
  // steps only while every lower digit was 0 before the edge. A stepping
  // zero digit reloads to 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         step;
    r    = v;
    step = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (step) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          step        = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // All-nines value used for the wrap.
  function automatic logic [W-1:0] all_nines();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         borrow_q, borrow_d;
  logic         done_q, done_d;
  logic         count_is_zero;

  assign count_is_zero = (count_q == '0);

  // Next-state: load beats enable; enable decrements, wraps or saturates.
  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
    done_d   = 1'b0;
    if (load) begin
      count_d = clamp_bcd(load_val);
    end else if (en) begin
      if (count_is_zero) begin
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
        count_d  = count_q;
`else
        count_d  = all_nines();
        borrow_d = 1'b1;
`endif
      end else begin
        count_d = bcd_decrement(count_q);
        done_d  = (count_q == COUNT_ONE);
      end
    end
  end

  // State registers; reset clears everything at once, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign count  = count_q;
  assign zero   = count_is_zero;
  assign borrow = borrow_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter with DIGITS=2. Expectations for the
// wrap/saturate cases follow BCD_DOWN_COUNTER_SATURATE_EN.
module tb_bcd_down_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       zero;
  logic       borrow;
  logic       done;

  int n_cmp;
  int n_err;

  bcd_down_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .borrow   (borrow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] c, input logic z,
                           input logic b, input logic d);
    check({tag, ".count"},  count, c);
    check({tag, ".zero"},   {7'd0, zero}, {7'd0, z});
    check({tag, ".borrow"}, {7'd0, borrow}, {7'd0, b});
    check({tag, ".done"},   {7'd0, done}, {7'd0, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 8'h00;

    // Reset takes effect before any clock edge.
    #2;
    check_all("rst_async", 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    check_all("rst_hold", 8'h00, 1'b1, 1'b0, 1'b0);

    // Load 23.
    load = 1'b1; load_val = 8'h23;
    step();
    load = 1'b0;
    check_all("load23", 8'h23, 1'b0, 1'b0, 1'b0);

    // Cross-digit decrement 21 -> 20 -> 19 -> 18.
    load = 1'b1; load_val = 8'h21;
    step();
    load = 1'b0; en = 1'b1;
    check_all("load21", 8'h21, 1'b0, 1'b0, 1'b0);
    step(); check_all("dec20", 8'h20, 1'b0, 1'b0, 1'b0);
    step(); check_all("dec19", 8'h19, 1'b0, 1'b0, 1'b0);
    step(); check_all("dec18", 8'h18, 1'b0, 1'b0, 1'b0);
    en = 1'b0;

    // Reach zero, then wrap (or saturate).
    load = 1'b1; load_val = 8'h02;
    step();
    load = 1'b0; en = 1'b1;
    check_all("load02", 8'h02, 1'b0, 1'b0, 1'b0);
    step(); check_all("dec01", 8'h01, 1'b0, 1'b0, 1'b0);
    step(); check_all("dec00", 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
    step(); check_all("sat00a", 8'h00, 1'b1, 1'b0, 1'b0);
    step(); check_all("sat00b", 8'h00, 1'b1, 1'b0, 1'b0);
`else
    step(); check_all("wrap99", 8'h99, 1'b0, 1'b1, 1'b0);
    step(); check_all("dec98", 8'h98, 1'b0, 1'b0, 1'b0);
`endif
    en = 1'b0;

    // Load 01 then four enabled clocks.
    load = 1'b1; load_val = 8'h01;
    step();
    load = 1'b0; en = 1'b1;
    check_all("load01", 8'h01, 1'b0, 1'b0, 1'b0);
    step(); check_all("s1", 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
    step(); check_all("s2", 8'h00, 1'b1, 1'b0, 1'b0);
    step(); check_all("s3", 8'h00, 1'b1, 1'b0, 1'b0);
    step(); check_all("s4", 8'h00, 1'b1, 1'b0, 1'b0);
`else
    step(); check_all("s2", 8'h99, 1'b0, 1'b1, 1'b0);
    step(); check_all("s3", 8'h98, 1'b0, 1'b0, 1'b0);
    step(); check_all("s4", 8'h97, 1'b0, 1'b0, 1'b0);
`endif

    // Load beats enable; both digits clamp to 9.
    load = 1'b1; load_val = 8'hAF;
    step();
    load = 1'b0; en = 1'b0;
    check_all("clampAF", 8'h99, 1'b0, 1'b0, 1'b0);

    // Hold for five clocks.
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("hold99", 8'h99, 1'b0, 1'b0, 1'b0);
    end

    // Loading zero does not produce done.
    load = 1'b1; load_val = 8'h00;
    step();
    load = 1'b0;
    check_all("load00", 8'h00, 1'b1, 1'b0, 1'b0);

    // Async reset clears a pending done pulse immediately.
    load = 1'b1; load_val = 8'h01;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check_all("pre_rst_done", 8'h00, 1'b1, 1'b0, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_all("rst_done_clr", 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    en = 1'b0;

    // Async reset mid-count at 57.
    load = 1'b1; load_val = 8'h58;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check_all("cnt57", 8'h57, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_all("rst_mid", 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    check_all("rst_held", 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
    check_all("post_rst", 8'h00, 1'b1, 1'b0, 1'b0);
`else
    check_all("post_rst", 8'h99, 1'b0, 1'b1, 1'b0);
`endif
    step();
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
    check_all("post_rst2", 8'h00, 1'b1, 1'b0, 1'b0);
`else
    check_all("post_rst2", 8'h98, 1'b0, 1'b0, 1'b0);
`endif
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
